boot_copy_engine: RTL and testbench

- Parametrised boot sequencer: copies a block of bytes from a synchronous ROM into system RAM over the core's download interface (dn_go/dn_wr/dn_addr/dn_data), then pulses execute.
- Successor to the fixed 276-byte post-reset loader in the PCW top level; adds configurable widths, ROM read latency, source/destination bases, run-time length, back-pressure, explicit start and status flags.
- Sits between the boot ROM and pcw_core; one instance per top level.

---
 rtl/boot_copy_engine_if.sv | 24 ++
 rtl/boot_copy_engine.sv | 121 ++++++++++++
 tb/tb_boot_copy_engine.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_engine_if.sv
// ROM read port and download-window bus between the boot copy engine and its neighbours.
// master: the copy engine; slave: the ROM/RAM side.
interface boot_copy_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              dn_wait;
  logic              dn_go;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;

  modport master (
    output rom_addr, dn_go, dn_wr, dn_addr, dn_data,
    input  rom_data, dn_wait
  );

  modport slave (
    input  rom_addr, dn_go, dn_wr, dn_addr, dn_data,
    output rom_data, dn_wait
  );
endinterface

// File: rtl/boot_copy_engine.sv
// Boot sequencer: copies length bytes from a synchronous ROM into RAM over the
// download interface, then pulses execute_enable with the latched entry address.
module boot_copy_engine #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1,
  parameter int AUTO_START  = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [ADDR_W-1:0]    dst_base,
  input  logic [ADDR_W-1:0]    length,
  input  logic [ADDR_W-1:0]    exec_addr,
  boot_copy_engine_if.master   bus,
  output logic                 execute_enable,
  output logic [ADDR_W-1:0]    execute_addr,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] LAT_LAST = 2'(ROM_LATENCY - 1);

  logic [2:0]        state;
  logic [1:0]        lat_cnt;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] exec_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic [DATA_W-1:0] rom_byte;
  logic              reset_q;
  logic              trigger;

  assign cnt_next = cnt + ADDR_W'(1);
  assign rom_byte = bus.rom_data;
  // reset_q marks the first cycle after reset release for the automatic copy
  assign trigger  = start || ((AUTO_START != 0) && reset_q);

  // rom_addr doubles as the source pointer; ROM data is sampled on the edge that
  // issues the write, so dn_data only ever changes together with dn_wr.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= S_IDLE;
      lat_cnt        <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      exec_q         <= '0;
      cnt            <= '0;
      reset_q        <= 1'b1;
      bus.rom_addr   <= '0;
      bus.dn_go      <= 1'b0;
      bus.dn_wr      <= 1'b0;
      bus.dn_addr    <= '0;
      bus.dn_data    <= '0;
      execute_enable <= 1'b0;
      execute_addr   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      reset_q        <= 1'b0;
      bus.dn_wr      <= 1'b0;
      execute_enable <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (trigger) begin
            dst_q        <= dst_base;
            len_q        <= length;
            exec_q       <= exec_addr;
            cnt          <= '0;
            lat_cnt      <= '0;
            bus.rom_addr <= src_base;
            bus.dn_go    <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= (length == '0) ? S_EXEC : S_FETCH;
          end
        end
        S_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            state <= S_WRITE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (!bus.dn_wait) begin
            bus.dn_wr   <= 1'b1;
            bus.dn_addr <= dst_q + cnt;
            bus.dn_data <= rom_byte;
            cnt         <= cnt_next;
            lat_cnt     <= '0;
            if (cnt_next == len_q) begin
              state <= S_EXEC;
            end else begin
              bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
              state        <= S_FETCH;
            end
          end
        end
        S_EXEC: begin
          execute_enable <= 1'b1;
          execute_addr   <= exec_q;
          bus.dn_go      <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b1;
          state          <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_copy_engine.sv
// Bench for boot_copy_engine: two instances (ROM latency 1 with auto start, latency 3
// without) against a queue-based model of the expected write stream and execute pulse.
module tb_boot_copy_engine;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int addr; int cyc; } ex_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic        reset;
  logic        start1, start3;
  logic [15:0] src1, dst1, len1, ex1;
  logic [15:0] src3, dst3, len3, ex3;
  logic        ee1, ee3, busy1, busy3, done1, done3;
  logic [15:0] ea1, ea3;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom_mem [0:65535];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [0:2];

  wr_t wq1[$], wq3[$];
  ex_t eq1[$], eq3[$];
  int  viol1 = 0, viol3 = 0;
  logic prev1 = 1'b0, prev3 = 1'b0;

  boot_copy_engine_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();
  boot_copy_engine_if #(.ADDR_W(16), .DATA_W(8)) bus3 ();

  boot_copy_engine #(.ADDR_W(16), .DATA_W(8), .ROM_LATENCY(1), .AUTO_START(1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .start(start1),
    .src_base(src1), .dst_base(dst1), .length(len1), .exec_addr(ex1),
    .bus(bus1), .execute_enable(ee1), .execute_addr(ea1), .busy(busy1), .done(done1)
  );

  boot_copy_engine #(.ADDR_W(16), .DATA_W(8), .ROM_LATENCY(3), .AUTO_START(0)) dut3 (
    .clk_sys(clk_sys), .reset(reset), .start(start3),
    .src_base(src3), .dst_base(dst3), .length(len3), .exec_addr(ex3),
    .bus(bus3), .execute_enable(ee3), .execute_addr(ea3), .busy(busy3), .done(done3)
  );

  // Synchronous ROMs: data appears ROM_LATENCY clocks after the address.
  always @(posedge clk_sys) begin
    pipe1    <= rom_mem[bus1.rom_addr];
    pipe3[0] <= rom_mem[bus3.rom_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus1.rom_data = pipe1;
  assign bus3.rom_data = pipe3[2];

  always @(negedge clk_sys) begin
    if (bus1.dn_wr === 1'b1) begin
      wq1.push_back('{int'(bus1.dn_addr), int'(bus1.dn_data), cyc});
      if (bus1.dn_go !== 1'b1 || prev1) viol1++;
    end
    prev1 = (bus1.dn_wr === 1'b1);
    if (ee1 === 1'b1) eq1.push_back('{int'(ea1), cyc});
    if (bus3.dn_wr === 1'b1) begin
      wq3.push_back('{int'(bus3.dn_addr), int'(bus3.dn_data), cyc});
      if (bus3.dn_go !== 1'b1 || prev3) viol3++;
    end
    prev3 = (bus3.dn_wr === 1'b1);
    if (ee3 === 1'b1) eq3.push_back('{int'(ea3), cyc});
  end

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until the chosen instance pulses execute_enable; the optional dn_wait
  // pattern is relative to the trigger cycle t (FETCH noise on byte 1, 5-cycle stall on byte 2).
  task automatic run_to_exec(input int which, input int t, input bit stall, input int budget);
    int rel;
    for (int k = 0; k < budget; k++) begin
      rel = cyc - t;
      if (stall) bus3.dn_wait = ((rel >= 5 && rel <= 6) || (rel >= 11 && rel <= 15));
      if ((which == 1 ? eq1.size() : eq3.size()) != 0) break;
      step();
    end
    bus3.dn_wait = 1'b0;
    check_output("exec_within_budget", (which == 1 ? eq1.size() : eq3.size()) != 0, 1);
  endtask

  task automatic check_copy(input int which, input int src, input int dst, input int len,
                            input int t, input int lat, input int stall_at, input int stall_n,
                            input int exaddr);
    int  sz, esz, nbad, ea, ed, ec, last;
    wr_t w;
    ex_t e;
    sz = (which == 1) ? wq1.size() : wq3.size();
    check_output("write_count", sz, len);
    nbad = 0;
    for (int i = 0; i < sz && i < len; i++) begin
      w  = (which == 1) ? wq1[i] : wq3[i];
      ea = (dst + i) & 32'hFFFF;
      ed = int'(rom_mem[(src + i) & 32'hFFFF]);
      ec = t + (lat + 1) * (i + 1) + ((stall_n > 0 && i >= stall_at) ? stall_n : 0);
      if (w.addr != ea || w.data != ed || w.cyc != ec) begin
        if (nbad == 0)
          $display("[TB] dut%0d write %0d: addr %h data %h cycle %0d, model addr %h data %h cycle %0d",
                   which, i, w.addr, w.data, w.cyc, ea, ed, ec);
        nbad++;
      end
    end
    check_output("write_stream_bad_entries", nbad, 0);
    esz = (which == 1) ? eq1.size() : eq3.size();
    check_output("exec_pulse_count", esz, 1);
    if (esz > 0) begin
      e    = (which == 1) ? eq1[0] : eq3[0];
      last = t + (lat + 1) * len + ((stall_n > 0 && len > stall_at) ? stall_n : 0);
      check_output("exec_cycle", e.cyc, last + 1);
      check_output("exec_addr", e.addr, exaddr);
    end
  endtask

  task automatic clear_queues();
    wq1.delete(); wq3.delete(); eq1.delete(); eq3.delete();
  endtask

  initial begin
    int t;
    int s_src, s_dst, s_len, s_ex;

    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'($urandom);
    reset = 1'b1;
    start1 = 1'b0; start3 = 1'b0;
    src1 = 16'h0000; dst1 = 16'h0000; len1 = 16'd276; ex1 = 16'($urandom);
    src3 = 16'h0000; dst3 = 16'h0000; len3 = 16'd0;   ex3 = 16'h0000;
    bus1.dn_wait = 1'b0; bus3.dn_wait = 1'b0;
    repeat (3) step();
    check_output("reset_outputs_dut1",
      {busy1, done1, ee1, bus1.dn_go, bus1.dn_wr, bus1.rom_addr, bus1.dn_addr, bus1.dn_data, ea1}, 0);
    check_output("reset_outputs_dut3",
      {busy3, done3, ee3, bus3.dn_go, bus3.dn_wr, bus3.rom_addr, bus3.dn_addr, bus3.dn_data, ea3}, 0);

    // Automatic 276-byte boot copy on reset release
    reset = 1'b0;
    step();
    t = cyc;
    check_output("autostart_busy_done_go", {busy1, done1, bus1.dn_go}, 3'b101);
    check_output("autostart_rom_addr", bus1.rom_addr, 16'h0000);
    check_output("no_autostart_dut3", busy3, 1'b0);
    run_to_exec(1, t, 1'b0, 1200);
    step();
    check_copy(1, 0, 0, 276, t, 1, 0, 0, int'(ex1));
    check_output("after_boot_busy_done_go", {busy1, done1, bus1.dn_go}, 3'b010);

    // Reset at byte 100 with start held alongside reset, then automatic restart
    clear_queues();
    src1 = 16'($urandom); dst1 = 16'($urandom); ex1 = 16'($urandom);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 400 && wq1.size() < 100; k++) step();
    check_output("reached_byte_100", wq1.size(), 100);
    reset = 1'b1; start1 = 1'b1; start3 = 1'b1;
    step();
    check_output("midcopy_reset_dut1",
      {busy1, done1, ee1, bus1.dn_go, bus1.dn_wr, bus1.rom_addr, bus1.dn_addr, bus1.dn_data, ea1}, 0);
    check_output("midcopy_reset_dut3", {busy3, done3, bus3.dn_go, bus3.dn_wr}, 0);
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    clear_queues();
    step();
    t = cyc;
    run_to_exec(1, t, 1'b0, 1200);
    step();
    check_copy(1, int'(src1), int'(dst1), 276, t, 1, 0, 0, int'(ex1));
    check_output("start_with_reset_no_copy_dut3", {wq3.size() == 0, busy3, done3}, 3'b100);

    // start while busy is ignored
    clear_queues();
    s_src = int'($urandom_range(0, 65535)); s_dst = int'($urandom_range(0, 65535));
    s_len = 10; s_ex = int'($urandom_range(0, 65535));
    src1 = 16'(s_src); dst1 = 16'(s_dst); len1 = 16'(s_len); ex1 = 16'(s_ex);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    t = cyc;
    repeat (3) step();
    src1 = 16'($urandom); dst1 = 16'($urandom); len1 = 16'd50; ex1 = 16'($urandom);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    run_to_exec(1, t, 1'b0, 200);
    repeat (4) step();
    check_copy(1, s_src, s_dst, s_len, t, 1, 0, 0, s_ex);

    // Latency 3 copy with destination wrap
    clear_queues();
    src3 = 16'h0100; dst3 = 16'hFFFE; len3 = 16'd4; ex3 = 16'($urandom);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    t = cyc;
    check_output("wrap_trigger_busy_done_go", {busy3, done3, bus3.dn_go}, 3'b101);
    check_output("wrap_trigger_rom_addr", bus3.rom_addr, 16'h0100);
    run_to_exec(3, t, 1'b0, 100);
    step();
    check_copy(3, 32'h0100, 32'hFFFE, 4, t, 3, 0, 0, int'(ex3));
    check_output("wrap_done", {busy3, done3}, 2'b01);

    // New copy from DONE with back-pressure on byte 2
    clear_queues();
    s_src = int'($urandom_range(0, 65535)); s_dst = int'($urandom_range(0, 65535));
    s_ex = int'($urandom_range(0, 65535));
    src3 = 16'(s_src); dst3 = 16'(s_dst); len3 = 16'd6; ex3 = 16'(s_ex);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    t = cyc;
    check_output("restart_from_done_clears_done", {busy3, done3}, 2'b10);
    run_to_exec(3, t, 1'b1, 200);
    step();
    check_copy(3, s_src, s_dst, 6, t, 3, 2, 5, s_ex);

    // Zero-length copy
    clear_queues();
    len3 = 16'd0; ex3 = 16'($urandom);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    t = cyc;
    check_output("len0_window_open", {bus3.dn_go, busy3, done3, ee3}, 4'b1100);
    step();
    check_output("len0_exec_cycle", {bus3.dn_go, busy3, done3, ee3}, 4'b0011);
    step();
    check_copy(3, 0, 0, 0, t, 3, 0, 0, int'(ex3));

    check_output("dn_wr_protocol_dut1", viol1, 0);
    check_output("dn_wr_protocol_dut3", viol3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
